// File: rtl/step_sequencer_pkg.sv
// ============================================================================
// Module   : step_sequencer_pkg
// Brief    : Shared types and constants for the step/direction sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package step_sequencer_pkg;

    localparam int DEFAULT_COUNT_W  = 32;
    localparam int DEFAULT_PERIOD_W = 16;

    localparam logic [7:0] c_MIN_TIME = 8'd1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DIR_SETUP = 2'd1,
        STEP_HIGH = 2'd2,
        STEP_LOW  = 2'd3
    } step_seq_state_t;

    function automatic logic [7:0] clamp_min(input logic [7:0] value);
        return (value < c_MIN_TIME) ? c_MIN_TIME : value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/step_seq_downcounter.sv
// ============================================================================
// Module   : step_seq_downcounter
// Brief    : Loadable down-counter that stops at zero and flags it.
// Revision : 1.0
// ============================================================================
`default_nettype none

module step_seq_downcounter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_enable,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/step_sequencer.sv
// ============================================================================
// Module   : step_sequencer
// Brief    : Command-driven step/dir pulse generator for the microstepper.
//            Optional signed position tracking: STEP_SEQUENCER_POSITION_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module step_sequencer
    import step_sequencer_pkg::*;
#(
    parameter int COUNT_W  = DEFAULT_COUNT_W,
    parameter int PERIOD_W = DEFAULT_PERIOD_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [COUNT_W-1:0]  cmd_steps,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic [7:0]          config_step_width,
    input  logic [7:0]          config_dir_setup,
    input  logic                abort,
    output logic                step,
    output logic                dir,
    output logic                busy,
    output logic                done,
    output logic                aborted,
`ifdef STEP_SEQUENCER_POSITION_EN
    input  logic                position_clear,
    output logic [COUNT_W-1:0]  position,
`endif
    output logic [COUNT_W-1:0]  steps_remaining
);

    step_seq_state_t     r_state, w_next;
    logic                r_dir, r_done, r_aborted, r_abort_pend;
    logic [COUNT_W-1:0]  r_remaining;
    logic [7:0]          r_width;
    logic [PERIOD_W-1:0] r_period;

    logic                w_accept, w_dir_change, w_enter_high, w_end;
    logic                w_phase_zero, w_period_zero;
    logic                w_phase_load_en, w_phase_en, w_period_en;
    logic [7:0]          w_cmd_width, w_cmd_setup, w_phase_load;
    logic [PERIOD_W-1:0] w_width_plus1, w_cmd_period, w_period_load;

    assign w_cmd_width   = clamp_min(config_step_width);
    assign w_cmd_setup   = clamp_min(config_dir_setup);
    assign w_width_plus1 = PERIOD_W'(w_cmd_width) + PERIOD_W'(1);
    assign w_cmd_period  = (cmd_period < w_width_plus1) ? w_width_plus1 : cmd_period;

    assign w_accept      = (r_state == IDLE) && cmd_valid;
    assign w_dir_change  = (cmd_dir != r_dir);
    assign w_enter_high  = (w_next == STEP_HIGH) && (r_state != STEP_HIGH);
    assign w_end         = (r_state != IDLE) && (w_next == IDLE);

    // Timers are loaded with N-1 so the zero flag marks the last cycle of a phase.
    assign w_phase_load_en = w_enter_high || ((r_state == IDLE) && (w_next == DIR_SETUP));
    assign w_phase_load    = (r_state == IDLE) ? ((w_dir_change ? w_cmd_setup : w_cmd_width) - 8'd1)
                                               : (r_width - 8'd1);
    assign w_period_load   = ((r_state == IDLE) ? w_cmd_period : r_period) - PERIOD_W'(1);
    assign w_phase_en      = (r_state == DIR_SETUP) || (r_state == STEP_HIGH);
    assign w_period_en     = (r_state == STEP_HIGH) || (r_state == STEP_LOW);

    step_seq_downcounter #(.WIDTH(8)) u_phase_timer (
        .clk          (clk),
        .resetn       (resetn),
        .i_load       (w_phase_load_en),
        .i_load_value (w_phase_load),
        .i_enable     (w_phase_en),
        .o_zero       (w_phase_zero)
    );

    step_seq_downcounter #(.WIDTH(PERIOD_W)) u_period_timer (
        .clk          (clk),
        .resetn       (resetn),
        .i_load       (w_enter_high),
        .i_load_value (w_period_load),
        .i_enable     (w_period_en),
        .o_zero       (w_period_zero)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (cmd_valid && (cmd_steps != '0)) begin
                    w_next = w_dir_change ? DIR_SETUP : STEP_HIGH;
                end
            end
            DIR_SETUP: begin
                if (abort) begin
                    w_next = IDLE;
                end else if (w_phase_zero) begin
                    w_next = STEP_HIGH;
                end
            end
            STEP_HIGH: begin
                // A pending abort only takes effect once the pulse is complete.
                if (w_phase_zero) begin
                    w_next = (abort || r_abort_pend) ? IDLE : STEP_LOW;
                end
            end
            STEP_LOW: begin
                if (abort) begin
                    w_next = IDLE;
                end else if (w_period_zero) begin
                    w_next = (r_remaining != '0) ? STEP_HIGH : IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == IDLE);
        busy      = (r_state != IDLE);
        step      = (r_state == STEP_HIGH);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dir        <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_abort_pend <= 1'b0;
            r_remaining  <= '0;
            r_width      <= c_MIN_TIME;
            r_period     <= '0;
        end else begin
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_abort_pend <= (r_state == STEP_HIGH) && (w_next == STEP_HIGH) && (abort || r_abort_pend);
            if (w_accept) begin
                r_width  <= w_cmd_width;
                r_period <= w_cmd_period;
                if (cmd_steps == '0) begin
                    r_remaining <= '0;
                    r_done      <= 1'b1;
                end else begin
                    r_dir       <= cmd_dir;
                    r_remaining <= (w_next == STEP_HIGH) ? (cmd_steps - COUNT_W'(1)) : cmd_steps;
                end
            end else if (w_enter_high) begin
                r_remaining <= r_remaining - COUNT_W'(1);
            end
            if (w_end) begin
                r_done    <= 1'b1;
                r_aborted <= abort || r_abort_pend;
            end
        end
    end

`ifdef STEP_SEQUENCER_POSITION_EN
    logic [COUNT_W-1:0] r_position;
    logic [COUNT_W-1:0] w_pos_delta;

    // On every STEP_HIGH entry r_dir already holds the direction of that step.
    assign w_pos_delta = r_dir ? COUNT_W'(1) : '1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_position <= '0;
        end else if (position_clear) begin
            r_position <= w_enter_high ? w_pos_delta : '0;
        end else if (w_enter_high) begin
            r_position <= r_position + w_pos_delta;
        end
    end

    assign position = r_position;
`endif

    assign dir             = r_dir;
    assign done            = r_done;
    assign aborted         = r_aborted;
    assign steps_remaining = r_remaining;

endmodule

`default_nettype wire

// File: tb/tb_step_sequencer.sv
// ============================================================================
// Module   : tb_step_sequencer
// Brief    : Directed vector table plus hand sequences for step_sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_step_sequencer;

    localparam int COUNT_W  = 32;
    localparam int PERIOD_W = 16;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic                cmd_valid = 1'b0;
    logic                cmd_dir = 1'b0;
    logic [COUNT_W-1:0]  cmd_steps = '0;
    logic [PERIOD_W-1:0] cmd_period = '0;
    logic [7:0]          config_step_width = '0;
    logic [7:0]          config_dir_setup = '0;
    logic                abort = 1'b0;
    logic                cmd_ready, step, dir, busy, done, aborted;
    logic [COUNT_W-1:0]  steps_remaining;
`ifdef STEP_SEQUENCER_POSITION_EN
    logic                position_clear = 1'b0;
    logic [COUNT_W-1:0]  position;
`endif

    step_sequencer #(.COUNT_W(COUNT_W), .PERIOD_W(PERIOD_W)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_dir           (cmd_dir),
        .cmd_steps         (cmd_steps),
        .cmd_period        (cmd_period),
        .config_step_width (config_step_width),
        .config_dir_setup  (config_dir_setup),
        .abort             (abort),
        .step              (step),
        .dir               (dir),
        .busy              (busy),
        .done              (done),
        .aborted           (aborted),
`ifdef STEP_SEQUENCER_POSITION_EN
        .position_clear    (position_clear),
        .position          (position),
`endif
        .steps_remaining   (steps_remaining)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Cycle numbers count from the accept edge: cycle 1 is the first cycle after it.
    typedef struct {
        logic dir;
        int   steps;
        int   period;
        int   width;
        int   setup;
        int   abort_at;
        int   e_dir_cyc;
        int   e_first;
        int   e_nrises;
        int   e_spacing;
        int   e_high;
        int   e_done;
        logic e_aborted;
        int   e_rem;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input string tag, input vec_t v);
        int   rises, last_rise, first_rise, hi_cnt, dir_cyc, done_cyc;
        logic prev_step, prev_dir, dir_before, busy1, got_abt, got_ready;
        logic [COUNT_W-1:0] got_rem;
        rises = 0; last_rise = 0; first_rise = 0; hi_cnt = 0; dir_cyc = 0; done_cyc = 0;
        got_abt = 1'b0; got_ready = 1'b0; got_rem = '0; busy1 = 1'b0;
        @(negedge clk);
        cmd_valid         = 1'b1;
        cmd_dir           = v.dir;
        cmd_steps         = COUNT_W'(v.steps);
        cmd_period        = PERIOD_W'(v.period);
        config_step_width = 8'(v.width);
        config_dir_setup  = 8'(v.setup);
        prev_step  = step;
        prev_dir   = dir;
        dir_before = dir;
        @(posedge clk);
        for (int cyc = 1; cyc <= 400 && done_cyc == 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                busy1     = busy;
                cmd_valid = 1'b0;
            end
            if ((dir !== prev_dir) && (dir_cyc == 0)) dir_cyc = cyc;
            if (step && !prev_step) begin
                rises++;
                if (rises == 1) first_rise = cyc;
                else check({tag, "_spacing"}, 64'(cyc - last_rise), 64'(v.e_spacing));
                last_rise = cyc;
                hi_cnt    = 0;
            end
            if (step) hi_cnt++;
            if (!step && prev_step) check({tag, "_high"}, 64'(hi_cnt), 64'(v.e_high));
            prev_step = step;
            prev_dir  = dir;
            if (done) begin
                done_cyc  = cyc;
                got_abt   = aborted;
                got_rem   = steps_remaining;
                got_ready = cmd_ready;
            end
            abort = (cyc == v.abort_at);
        end
        abort     = 1'b0;
        cmd_valid = 1'b0;
        check({tag, "_done_cycle"}, 64'(done_cyc), 64'(v.e_done));
        check({tag, "_aborted"}, 64'(got_abt), 64'(v.e_aborted));
        check({tag, "_remaining"}, 64'(got_rem), 64'(v.e_rem));
        check({tag, "_ready_at_done"}, 64'(got_ready), 64'd1);
        check({tag, "_busy_cycle1"}, 64'(busy1), (v.steps != 0) ? 64'd1 : 64'd0);
        check({tag, "_first_rise"}, 64'(first_rise), 64'(v.e_first));
        check({tag, "_num_rises"}, 64'(rises), 64'(v.e_nrises));
        check({tag, "_dir_change_cycle"}, 64'(dir_cyc), 64'(v.e_dir_cyc));
        check({tag, "_final_dir"}, 64'(dir), (v.steps == 0) ? 64'(dir_before) : 64'(v.dir));
    endtask

    initial begin
        //           dir   steps per wid set abt  dcyc first n  sp  hi  done ab    rem
        vecs[0] = '{1'b0,   4,  10,  3,  1,  0,   0,   1,   4, 10, 3,  41, 1'b0,  0};
        vecs[1] = '{1'b1,   1,  10,  3,  5,  0,   1,   6,   1, 10, 3,  16, 1'b0,  0};
        vecs[2] = '{1'b1,   3,   2,  4,  0,  0,   0,   1,   3,  5, 4,  16, 1'b0,  0};
        vecs[3] = '{1'b0,   0,  10,  3,  1,  0,   0,   0,   0,  0, 0,   1, 1'b0,  0};
        vecs[4] = '{1'b1, 100,  20,  6,  1,  2,   0,   1,   1, 20, 6,   7, 1'b1, 99};
        vecs[5] = '{1'b0,   3,   0,  0,  0,  0,   1,   2,   3,  2, 1,   8, 1'b0,  0};
        vecs[6] = '{1'b1,   7,  10,  3,  5,  3,   1,   0,   0, 10, 3,   4, 1'b1,  7};
        vecs[7] = '{1'b1,   5,  10,  2,  0,  5,   0,   1,   1, 10, 2,   6, 1'b1,  4};

        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("reset_step", 64'(step), 64'd0);
        check("reset_dir", 64'(dir), 64'd0);
        check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_aborted", 64'(aborted), 64'd0);
        check("reset_remaining", 64'(steps_remaining), 64'd0);
`ifdef STEP_SEQUENCER_POSITION_EN
        check("reset_position", 64'(position), 64'd0);
`endif

        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Abort while idle must not start or end anything.
        @(negedge clk);
        abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_abort_busy", 64'(busy), 64'd0);
            check("idle_abort_done", 64'(done), 64'd0);
        end
        abort = 1'b0;

`ifdef STEP_SEQUENCER_POSITION_EN
        @(negedge clk);
        position_clear = 1'b1;
        @(negedge clk);
        position_clear = 1'b0;
        check("pos_clear_initial", 64'(position), 64'd0);
        run_vec("posA", '{1'b1, 3, 4, 1, 0, 0, 0, 1, 3, 4, 1, 13, 1'b0, 0});
        run_vec("posB", '{1'b0, 5, 4, 1, 2, 0, 1, 3, 5, 4, 1, 23, 1'b0, 0});
        check("pos_net_minus2", 64'(position), 64'(32'hFFFF_FFFE));
        @(negedge clk);
        position_clear = 1'b1;
        @(negedge clk);
        position_clear = 1'b0;
        check("pos_clear_final", 64'(position), 64'd0);
`endif

        // Asynchronous reset in the middle of a pulse.
        begin
            int waited;
            @(negedge clk);
            cmd_valid         = 1'b1;
            cmd_dir           = dir;
            cmd_steps         = COUNT_W'(10);
            cmd_period        = PERIOD_W'(10);
            config_step_width = 8'd5;
            config_dir_setup  = 8'd1;
            waited = 0;
            @(negedge clk);
            cmd_valid = 1'b0;
            while (!step && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            check("midreset_step_seen", 64'(step), 64'd1);
            #2;
            resetn = 1'b0;
            #1;
            check("midreset_step", 64'(step), 64'd0);
            check("midreset_busy", 64'(busy), 64'd0);
            check("midreset_ready", 64'(cmd_ready), 64'd1);
            check("midreset_dir", 64'(dir), 64'd0);
            check("midreset_remaining", 64'(steps_remaining), 64'd0);
            @(negedge clk);
            resetn = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
